stepper_move_sequencer: RTL
===========================

Name: stepper_move_sequencer

Overview:
- Upstream command stage for stepper_pulse.
- Accepts signed relative-move commands through a valid/ready FIFO and converts each into a direction level plus an unsigned pulse_count.
- Issues a one-cycle start to the pulse generator, waits for its done, then tracks the absolute axis position.
- Sits between the host/register interface and stepper_pulse, one instance per axis.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, at least 2.
- DIR_SETUP_CYCLES, 50, clk cycles dir must be stable before start (1 us at 50 MHz); at least 1.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_delta  in  32  signed relative step count
- abort  in  1  flush queue and cancel the current move
- pos_load  in  1  overwrite position
- pos_load_val  in  32  signed value for pos_load
- pulse_count  out  32  unsigned step count to stepper_pulse
- dir  out  1  1 = positive delta
- start  out  1  one-cycle move launch
- done  in  1  move-complete level from stepper_pulse
- stop  out  1  one-cycle cancel to stepper_pulse
- busy  out  1  move in progress or queue non-empty
- position  out  32  signed absolute position
- pos_valid  out  1  position is trustworthy

Behaviour:
- Reset values: cmd_ready=1, pulse_count=0, dir=0, start=0, stop=0, busy=0, position=0, pos_valid=1. The FIFO is empty and the FSM is in IDLE.
- FIFO:
  - A push occurs when cmd_valid && cmd_ready.
  - cmd_ready depends only on the registered full flag; there is no bypass and no push while full, even if a pop happens that cycle.
  - A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, SETUP, ISSUE, WAIT.
- IDLE: if FIFO non-empty, pop into cur_delta and go to LOAD.
- LOAD:
  - If cur_delta == 0, the move is discarded: no start, position unchanged, back to IDLE.
  - Otherwise register dir = (cur_delta > 0) and pulse_count = |cur_delta|.
  - -2^31 gives pulse_count = 0x8000_0000.
  - Go to SETUP.
- SETUP: count DIR_SETUP_CYCLES cycles with dir and pulse_count held, then go to ISSUE.
- ISSUE: start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - Completion is a rising edge of done (registered done_q=0, done=1).
  - A done already high on entry is ignored until it falls and rises again.
  - On completion: position <= position + cur_delta (32-bit two's-complement wrap, no saturation); go to IDLE.
- Latency: a push into an empty idle FIFO produces start exactly DIR_SETUP_CYCLES+3 cycles after the push edge.
- pulse_count and dir hold their last value in IDLE.
- busy = (state != IDLE) || FIFO non-empty.
- abort (synchronous, highest priority):
  - From any state: empty the FIFO and go to IDLE.
  - If the abort arrives in SETUP, ISSUE or WAIT, pulse stop=1 for one cycle and clear pos_valid, since the pulses actually emitted are unknown.
  - An abort in IDLE or LOAD leaves pos_valid unchanged.
  - A cmd push in the same cycle as abort is dropped.
  - start is never asserted in the abort cycle.
- pos_load:
  - position <= pos_load_val and pos_valid <= 1.
  - If a move completes in the same cycle, pos_load wins and the delta is discarded.
  - pos_load combined with abort: the abort effects apply and position/pos_valid take the pos_load values.
- Reset mid-move: all state returns to reset values immediately; the downstream block is reset by the same rst_n.

Test Plan:
1. Push cmd_delta=20 → dir=1, pulse_count=20, start 53 cycles after the push; done rises → position=20, busy=0.
2. Push +20, then −5 → second start follows the first done; dir drops to 0, pulse_count=5; final position=15.
3. Push 5 commands with FIFO_DEPTH=4 while the first is WAITing → cmd_ready=0 after the queue holds 4; 5th accepted only after a pop; all 5 executed in order.
4. Push 0 then +3 → no start for the 0; a single start with pulse_count=3; position=3.
5. abort during WAIT with 2 queued → stop pulses once, FIFO empty, busy=0, pos_valid=0; then pos_load=100 → position=100, pos_valid=1.
6. pos_load=0x7FFF_FFFF, then push +1 → pulse_count=1; position wraps to 0x8000_0000; push −2^31 → pulse_count=0x8000_0000, dir=0.

Source files
------------

// File: rtl/stepper_move_sequencer.sv
// Per-axis command sequencer. It queues signed relative moves, launches stepper_pulse
// with a direction setup delay, and tracks the absolute axis position.
module stepper_move_sequencer #(
    parameter int FIFO_DEPTH       = 4,
    parameter int DIR_SETUP_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_delta,
    input  logic        abort,
    input  logic        pos_load,
    input  logic [31:0] pos_load_val,
    output logic [31:0] pulse_count,
    output logic        dir,
    output logic        start,
    input  logic        done,
    output logic        stop,
    output logic        busy,
    output logic [31:0] position,
    output logic        pos_valid
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(DIR_SETUP_CYCLES + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic signed [31:0] cur_delta_q, cur_delta_d;
    logic               dir_q, dir_d;
    logic [31:0]        pulse_count_q, pulse_count_d;
    logic [CW-1:0]      setup_cnt_q, setup_cnt_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic               done_q;
    logic signed [31:0] position_q, position_d;
    logic               pos_valid_q, pos_valid_d;
    logic [31:0]        mem_q [FIFO_DEPTH];

    logic full, empty, push, pop, done_rise, move_active;

    // Magnitude of a signed delta; -2^31 maps to 0x8000_0000 as an unsigned count.
    function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
        logic [31:0] u;
        u = v;
        abs_mag = u[31] ? (~u + 32'd1) : u;
    endfunction

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign push        = cmd_valid && !full && !abort;
    assign pop         = (state_q == IDLE) && !empty && !abort;
    assign done_rise   = done && !done_q;
    assign move_active = (state_q == SETUP) || (state_q == ISSUE) || (state_q == WAIT);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        cur_delta_d   = cur_delta_q;
        dir_d         = dir_q;
        pulse_count_d = pulse_count_q;
        setup_cnt_d   = setup_cnt_q;
        start_d       = 1'b0;
        stop_d        = 1'b0;
        position_d    = position_q;
        pos_valid_d   = pos_valid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            cur_delta_d = $signed(mem_q[rd_ptr_q]);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cur_delta_q == 32'sd0) begin
                    state_d = IDLE;
                end else begin
                    dir_d         = (cur_delta_q > 32'sd0);
                    pulse_count_d = abs_mag(cur_delta_q);
                    setup_cnt_d   = '0;
                    state_d       = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    state_d = ISSUE;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    position_d = position_q + cur_delta_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything the FSM decided this cycle, including a completion.
        if (abort) begin
            state_d       = IDLE;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            start_d       = 1'b0;
            dir_d         = dir_q;
            pulse_count_d = pulse_count_q;
            position_d    = position_q;
            if (move_active) begin
                stop_d      = 1'b1;
                pos_valid_d = 1'b0;
            end
        end

        if (pos_load) begin
            position_d  = $signed(pos_load_val);
            pos_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cur_delta_q   <= '0;
            dir_q         <= 1'b0;
            pulse_count_q <= '0;
            setup_cnt_q   <= '0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            done_q        <= 1'b0;
            position_q    <= '0;
            pos_valid_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cur_delta_q   <= cur_delta_d;
            dir_q         <= dir_d;
            pulse_count_q <= pulse_count_d;
            setup_cnt_q   <= setup_cnt_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            done_q        <= done;
            position_q    <= position_d;
            pos_valid_q   <= pos_valid_d;
        end
    end

    // Queue storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_delta;
        end
    end

    assign cmd_ready   = !full;
    assign pulse_count = pulse_count_q;
    assign dir         = dir_q;
    assign start       = start_q;
    assign stop        = stop_q;
    assign busy        = (state_q != IDLE) || !empty;
    assign position    = position_q;
    assign pos_valid   = pos_valid_q;

endmodule
